hash_text_overlay: RTL and testbench

- Pixel-generation stage directly downstream of the VGA sync/counter generator.
- Consumes its pixel counters, display-area flag and sync outputs.
- Renders a 256-bit hash as one row of 64 hex characters (MSB nibble first) on a background band.
- Outputs 3-bit RGB plus syncs delayed to match its pipeline; hash updates are frame-synchronised to avoid tearing.

---
 rtl/hash_text_overlay.sv | 212 +++++++++++++++++++++
 tb/tb_hash_text_overlay.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_text_overlay.sv
// hash_text_overlay: draws a 256-bit hash as 64 hex glyphs (MSB nibble first) on a band,
// 3-cycle pixel pipeline, frame-synchronised hash update. OVERLAY_BORDER_EN adds a yellow frame.
//
// Pending-buffer FSM
//   state    | meaning
//   ST_EMPTY | no hash waiting; hash_ready high
//   ST_FULL  | hash held in pending buffer until the line-480 commit point
module hash_text_overlay #(
  parameter int         ORIGIN_X = 64,
  parameter int         ORIGIN_Y = 200,
  parameter logic [2:0] FG_RGB   = 3'b010,
  parameter logic [2:0] BG_RGB   = 3'b001
) (
  input  logic         pixel_clk,
  input  logic         reset_n,
  input  logic [9:0]   counter_x,
  input  logic [8:0]   counter_y,
  input  logic         in_display_area,
  input  logic         vga_h_sync_in,
  input  logic         vga_v_sync_in,
  input  logic [255:0] hash_in,
  input  logic         hash_valid,
  output logic         hash_ready,
  output logic         vga_r,
  output logic         vga_g,
  output logic         vga_b,
  output logic         vga_h_sync,
  output logic         vga_v_sync
);

  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + 511);
  localparam logic [8:0] Y_LO = 9'(ORIGIN_Y);
  localparam logic [8:0] Y_HI = 9'(ORIGIN_Y + 7);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} pend_state_t;

  pend_state_t    r_state;
  pend_state_t    w_state_nxt;
  logic [255:0]   r_pend_buf;
  logic [255:0]   r_disp_buf;
  logic           w_commit_pt;
  logic           w_xfer;
  logic           w_load;

  logic           w_in_band;
  logic [8:0]     w_dx;
  logic [2:0]     w_dy;
  logic           r_s1_band;
  logic           r_s1_de;
  logic [5:0]     r_s1_char;
  logic [2:0]     r_s1_col;
  logic [2:0]     r_s1_row;

  logic [3:0]     w_nibble;
  logic [7:0]     r_s2_glyph;
  logic [2:0]     r_s2_col;
  logic           r_s2_band;
  logic           r_s2_de;

  logic [2:0]     w_rgb_nxt;
  logic [2:0]     r_rgb;
  logic [2:0]     r_hs_d;
  logic [2:0]     r_vs_d;

  // Rows top to bottom in one 64-bit word; bit 7 of each row is the leftmost pixel.
  function automatic logic [7:0] font_rom(input logic [6:0] addr);
    logic [63:0] g;
    case (addr[6:3])
      4'h0: g = 64'h3C666E7666663C00;
      4'h1: g = 64'h1838181818187E00;
      4'h2: g = 64'h3C66060C18307E00;
      4'h3: g = 64'h3C66061C06663C00;
      4'h4: g = 64'h0C1C2C4C7E0C0C00;
      4'h5: g = 64'h7E607C0606663C00;
      4'h6: g = 64'h3C607C6666663C00;
      4'h7: g = 64'h7E060C1830303000;
      4'h8: g = 64'h3C66663C66663C00;
      4'h9: g = 64'h3C66663E060C3800;
      4'hA: g = 64'h183C66667E666600;
      4'hB: g = 64'h7C66667C66667C00;
      4'hC: g = 64'h3C66606060663C00;
      4'hD: g = 64'h786C6666666C7800;
      4'hE: g = 64'h7E60607C60607E00;
      default: g = 64'h7E60607C60606000;
    endcase
    return g[{~addr[2:0], 3'b000} +: 8];
  endfunction

  assign w_commit_pt = (counter_y == 9'd480) && (counter_x == 10'd0);
  assign w_xfer      = hash_valid && hash_ready;
  assign w_load      = (r_state == ST_FULL) && w_commit_pt;

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer)      w_state_nxt = ST_FULL;
      ST_FULL:  if (w_commit_pt) w_state_nxt = ST_EMPTY;
      default:                   w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    hash_ready = (r_state == ST_EMPTY);
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_pend_buf <= '0;
      r_disp_buf <= '0;
    end else begin
      if (w_xfer) r_pend_buf <= hash_in;
      if (w_load) r_disp_buf <= r_pend_buf;
    end
  end

  // Only the low bits of the offsets matter once the pixel is known to be in the band.
  assign w_in_band = in_display_area && (counter_x >= X_LO) && (counter_x <= X_HI) &&
                     (counter_y >= Y_LO) && (counter_y <= Y_HI);
  assign w_dx      = counter_x[8:0] - X_LO[8:0];
  assign w_dy      = counter_y[2:0] - Y_LO[2:0];

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_s1_band <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_char <= '0;
      r_s1_col  <= '0;
      r_s1_row  <= '0;
    end else begin
      r_s1_band <= w_in_band;
      r_s1_de   <= in_display_area;
      r_s1_char <= w_dx[8:3];
      r_s1_col  <= w_dx[2:0];
      r_s1_row  <= w_dy;
    end
  end

  // Char 0 is the most significant nibble: bit offset 4*(63-char).
  assign w_nibble = r_disp_buf[{~r_s1_char, 2'b00} +: 4];

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_s2_glyph <= '0;
      r_s2_col   <= '0;
      r_s2_band  <= 1'b0;
      r_s2_de    <= 1'b0;
    end else begin
      r_s2_glyph <= font_rom({w_nibble, r_s1_row});
      r_s2_col   <= r_s1_col;
      r_s2_band  <= r_s1_band;
      r_s2_de    <= r_s1_de;
    end
  end

`ifdef OVERLAY_BORDER_EN
  localparam logic [9:0] BX_L = 10'(ORIGIN_X - 1);
  localparam logic [9:0] BX_R = 10'(ORIGIN_X + 512);
  localparam logic [8:0] BY_T = 9'(ORIGIN_Y - 1);
  localparam logic [8:0] BY_B = 9'(ORIGIN_Y + 8);

  logic w_border;
  logic r_s1_border;
  logic r_s2_border;

  assign w_border = in_display_area &&
    ((((counter_x == BX_L) || (counter_x == BX_R)) && (counter_y >= BY_T) && (counter_y <= BY_B)) ||
     (((counter_y == BY_T) || (counter_y == BY_B)) && (counter_x >= BX_L) && (counter_x <= BX_R)));

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_s1_border <= 1'b0;
      r_s2_border <= 1'b0;
    end else begin
      r_s1_border <= w_border;
      r_s2_border <= r_s1_border;
    end
  end
`endif

  always_comb begin
    w_rgb_nxt = 3'b000;
    if (r_s2_de) begin
      if (r_s2_band) w_rgb_nxt = r_s2_glyph[~r_s2_col] ? FG_RGB : BG_RGB;
`ifdef OVERLAY_BORDER_EN
      else if (r_s2_border) w_rgb_nxt = 3'b110;
`endif
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_rgb  <= 3'b000;
      r_hs_d <= 3'b111;
      r_vs_d <= 3'b111;
    end else begin
      r_rgb  <= w_rgb_nxt;
      r_hs_d <= {r_hs_d[1:0], vga_h_sync_in};
      r_vs_d <= {r_vs_d[1:0], vga_v_sync_in};
    end
  end

  assign {vga_r, vga_g, vga_b} = r_rgb;
  assign vga_h_sync = r_hs_d[2];
  assign vga_v_sync = r_vs_d[2];

endmodule

// File: tb/tb_hash_text_overlay.sv
// Bench for hash_text_overlay: drives pixel coordinates directly and checks RGB/syncs
// against a glyph-level reference model. Honours OVERLAY_BORDER_EN when defined.
module tb_hash_text_overlay;

  localparam int OX = 64;
  localparam int OY = 200;
  localparam int FG = 2;
  localparam int BG = 1;

  logic         pixel_clk;
  logic         reset_n;
  logic [9:0]   counter_x;
  logic [8:0]   counter_y;
  logic         in_display_area;
  logic         vga_h_sync_in;
  logic         vga_v_sync_in;
  logic [255:0] hash_in;
  logic         hash_valid;
  logic         hash_ready;
  logic         vga_r, vga_g, vga_b;
  logic         vga_h_sync, vga_v_sync;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] m_disp, m_pend;
  bit           m_full;
  logic [255:0] drv_hash;
  bit           drv_valid;
  int           q_rgb[$];
  bit           q_hs[$];
  bit           q_vs[$];

  hash_text_overlay #(.ORIGIN_X(OX), .ORIGIN_Y(OY), .FG_RGB(3'b010), .BG_RGB(3'b001)) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .vga_h_sync_in(vga_h_sync_in), .vga_v_sync_in(vga_v_sync_in),
    .hash_in(hash_in), .hash_valid(hash_valid), .hash_ready(hash_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Known glyph facts: row 7 and column 0 blank, '0' row0 = 3C, 'F' row0 = 7E.
  // -1 means "some glyph pixel" (FG or BG) where the exact shape is not pinned down.
  function automatic int exp_pixel(int x, int y, bit de, logic [255:0] disp);
    int ci, col, row;
    logic [3:0] nib;
    logic [7:0] g0, gf;
    g0 = 8'h3C;
    gf = 8'h7E;
    if (!de) return 0;
    if (x >= OX && x <= OX + 511 && y >= OY && y <= OY + 7) begin
      ci  = (x - OX) / 8;
      col = (x - OX) % 8;
      row = y - OY;
      nib = disp[255 - 4*ci -: 4];
      if (row == 7 || col == 0) return BG;
      if (row == 0 && nib == 4'h0) return g0[7 - col] ? FG : BG;
      if (row == 0 && nib == 4'hF) return gf[7 - col] ? FG : BG;
      return -1;
    end
`ifdef OVERLAY_BORDER_EN
    if (((x == OX - 1 || x == OX + 512) && y >= OY - 1 && y <= OY + 8) ||
        ((y == OY - 1 || y == OY + 8) && x >= OX - 1 && x <= OX + 512)) return 6;
`endif
    return 0;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  function automatic logic [255:0] zf_hash();
    logic [255:0] h;
    for (int i = 0; i < 64; i++) h[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
    return h;
  endfunction

  // One pixel clock: drive at negedge, update model after the edge, compare output three stages back.
  task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
    bit xfer, commit;
    int e;
    logic [2:0] obs;
    @(negedge pixel_clk);
    chk("hash_ready", {2'b00, hash_ready}, {2'b00, !m_full});
    reset_n         = 1'b1;
    counter_x       = 10'(x);
    counter_y       = 9'(y);
    in_display_area = de;
    vga_h_sync_in   = hs;
    vga_v_sync_in   = vs;
    hash_valid      = drv_valid;
    hash_in         = drv_hash;
    q_rgb.push_back(exp_pixel(x, y, de, m_disp));
    q_hs.push_back(hs);
    q_vs.push_back(vs);
    xfer   = drv_valid && !m_full;
    commit = (x == 0) && (y == 480) && m_full;
    @(posedge pixel_clk);
    #1;
    if (commit) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (xfer) begin
      m_pend = drv_hash;
      m_full = 1'b1;
    end
    if (q_rgb.size() >= 3) begin
      e   = q_rgb.pop_front();
      obs = {vga_r, vga_g, vga_b};
      if (e >= 0) chk("rgb", obs, 3'(e));
      else begin
        n_tests++;
        assert ((obs === 3'(FG)) || (obs === 3'(BG))) else begin
          n_fail++;
          $error("FAIL rgb_glyph: observed %0h expected FG or BG", obs);
        end
      end
      chk("h_sync", {2'b00, vga_h_sync}, {2'b00, q_hs.pop_front()});
      chk("v_sync", {2'b00, vga_v_sync}, {2'b00, q_vs.pop_front()});
    end
  endtask

  task automatic do_reset();
    @(negedge pixel_clk);
    reset_n         = 1'b0;
    counter_x       = 10'($urandom_range(0, 1023));
    counter_y       = 9'($urandom_range(0, 511));
    in_display_area = 1'b1;
    vga_h_sync_in   = 1'($urandom_range(0, 1));
    vga_v_sync_in   = 1'($urandom_range(0, 1));
    hash_valid      = 1'b1;
    hash_in         = rand_hash();
    repeat (2) @(posedge pixel_clk);
    #1;
    chk("reset_rgb", {vga_r, vga_g, vga_b}, 3'b000);
    chk("reset_hs", {2'b00, vga_h_sync}, 3'b001);
    chk("reset_vs", {2'b00, vga_v_sync}, 3'b001);
    chk("reset_ready", {2'b00, hash_ready}, 3'b001);
    m_full = 1'b0;
    m_disp = '0;
    m_pend = '0;
    drv_valid = 1'b0;
    q_rgb.delete();
    q_hs.delete();
    q_vs.delete();
    repeat (2) begin
      q_rgb.push_back(0);
      q_hs.push_back(1'b1);
      q_vs.push_back(1'b1);
    end
  endtask

  task automatic idle();
    step(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic rand_step();
    int x, y;
    if ($urandom_range(0, 9) < 7) begin
      x = $urandom_range(OX - 2, OX + 513);
      y = $urandom_range(OY - 2, OY + 9);
    end else begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
    end
    step(x, y, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin : main
    logic [7:0] b63;
    reset_n = 1'b0;
    counter_x = '0; counter_y = '0; in_display_area = 1'b0;
    vga_h_sync_in = 1'b1; vga_v_sync_in = 1'b1;
    hash_in = '0; hash_valid = 1'b0;
    drv_hash = '0; drv_valid = 1'b0;
    m_full = 1'b0; m_disp = '0; m_pend = '0;

    do_reset();
    // Zero glyph after reset, latency via a single hsync pulse and band pixel
    step(OX + 2, OY, 1'b1, 1'b1, 1'b1);
    step(OX, OY, 1'b1, 1'b0, 1'b1);
    step(OX + 1, OY, 1'b1, 1'b1, 1'b0);
    repeat (3) idle();

    // Transfer all-F mid-frame; band keeps '0' until commit at (0,480)
    drv_hash = '1;
    drv_valid = 1'b1;
    step(100, 100, 1'b1, 1'b1, 1'b1);
    drv_valid = 1'b0;
    for (int c = 0; c < 8; c++) step(OX + c, OY, 1'b1, 1'b1, 1'b1);
    step(0, 480, 1'b0, 1'b1, 1'b1);
    idle();
    step(OX + 1, OY, 1'b1, 1'b1, 1'b1);
    step(OX + 2, OY, 1'b1, 1'b1, 1'b1);
    repeat (3) idle();

    // Band edges, blank glyph row, display-area gating, frame corners
    step(OX - 1, OY, 1'b1, 1'b1, 1'b1);
    step(OX + 512, OY, 1'b1, 1'b1, 1'b1);
    step(OX + 3, OY + 7, 1'b1, 1'b1, 1'b1);
    step(OX + 9, OY, 1'b0, 1'b1, 1'b1);
    step(OX - 1, OY - 1, 1'b1, 1'b1, 1'b1);
    step(OX + 512, OY + 8, 1'b1, 1'b1, 1'b1);
    step(OX + 511, OY + 7, 1'b1, 1'b1, 1'b1);
    step(OX + 200, OY + 8, 1'b1, 1'b1, 1'b1);
    repeat (3) idle();

    // Nibble order: hash 1 shows '1' only in char 63
    drv_hash = 256'h1;
    drv_valid = 1'b1;
    idle();
    drv_valid = 1'b0;
    step(0, 480, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 512; i++) step(OX + i, OY, 1'b1, 1'b1, 1'b1);
    repeat (3) idle();
    b63 = '0;
    for (int c = 0; c < 8; c++) begin
      step(OX + 504 + c, OY, 1'b1, 1'b1, 1'b1);
      idle();
      idle();
      b63[7 - c] = ({vga_r, vga_g, vga_b} === 3'(FG));
    end
    n_tests++;
    assert (b63 !== 8'h3C) else begin
      n_fail++;
      $error("FAIL char63_glyph: observed row0 %0h expected a glyph other than 3c", b63);
    end

    // Reset with a pending all-F hash: it must be dropped and the band cleared
    drv_hash = '1;
    drv_valid = 1'b1;
    step(200, 300, 1'b1, 1'b1, 1'b1);
    drv_valid = 1'b0;
    repeat (4) rand_step();
    do_reset();
    step(0, 480, 1'b0, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 32; i++) step(OX + i, OY, 1'b1, 1'b1, 1'b1);
    repeat (3) idle();

    // Randomised frames with frame-synchronised hash updates
    for (int r = 0; r < 8; r++) begin
      drv_hash = (r % 2 == 0) ? zf_hash() : rand_hash();
      repeat (100) rand_step();
      drv_valid = 1'b1;
      rand_step();
      drv_valid = 1'b0;
      repeat (150) rand_step();
      step(0, 480, 1'b0, 1'b1, 1'b1);
      repeat (150) rand_step();
    end
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
